// File: rtl/io_bus_controller.sv
// rtl/io_bus_controller.sv - memory-mapped I/O controller: data-memory routing, LED/switch/button window
// Switch and button inputs share one synchronizer/debounce path; edge capture is sticky W1C.
module io_bus_controller #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int CS_W      = 4,
    parameter int MEM_WORDS = 32,
    parameter int N_LEDS    = 8,
    parameter int N_SW      = 8,
    parameter int N_BTN     = 4,
    parameter int DEB_CYC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_enable,
    input  logic              r_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [CS_W-1:0]   cs_in,
    output logic              w_enable_data_mem,
    output logic [CS_W-1:0]   cs_out,
    output logic              io_sel,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rvalid,
    output logic [N_LEDS-1:0] leds_out,
    input  logic [N_SW-1:0]   sw_in,
    input  logic [N_BTN-1:0]  btn_in
);

    localparam int N_IN  = N_SW + N_BTN;
    localparam int CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] OFF_LED  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_SW   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_BTN  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] OFF_EDGE = ADDR_W'(3);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic [N_IN-1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_IN-1:0]             deb_q, deb_d;
    logic [N_IN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_LEDS-1:0]           leds_q, leds_d;
    logic [N_BTN-1:0]            edge_q, edge_d;
    logic [DATA_W-1:0]           io_rdata_q, io_rdata_d;
    logic                        io_rvalid_q, io_rvalid_d;

    logic [ADDR_W-1:0] off;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] rd_word;
    logic [N_BTN-1:0]  btn_rise, edge_clr;
    logic              led_wr, edge_wr;
    logic              unused_wdata;

    assign unused_wdata = ^wdata;

    always_comb begin
        io_sel            = (addr >= BASE);
        off               = addr - BASE;
        w_enable_data_mem = io_sel ? 1'b0 : w_enable;
        cs_out            = io_sel ? '0 : cs_in;
        led_wr            = w_enable && io_sel && (off == OFF_LED);
        edge_wr           = w_enable && io_sel && (off == OFF_EDGE);
        for (int b = 0; b < DATA_W; b++) begin
            wmask[b] = cs_in[b / 8];
        end
    end

    // Raw inputs are packed {buttons, switches} so one debounce loop serves both.
    always_comb begin
        sync1_d = {btn_in, sw_in};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < N_IN; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        leds_d = leds_q;
        for (int i = 0; i < N_LEDS; i++) begin
            if (led_wr && wmask[i]) begin
                leds_d[i] = wdata[i];
            end
        end
        btn_rise = deb_d[N_IN-1:N_SW] & ~deb_q[N_IN-1:N_SW];
        edge_clr = edge_wr ? (wdata[N_BTN-1:0] & wmask[N_BTN-1:0]) : '0;
        // Rise is OR-ed in after the clear so a simultaneous press is never lost.
        edge_d   = (edge_q & ~edge_clr) | btn_rise;
    end

    always_comb begin
        rd_word = '0;
        case (off)
            OFF_LED:  rd_word = DATA_W'(leds_q);
            OFF_SW:   rd_word = DATA_W'(deb_q[N_SW-1:0]);
            OFF_BTN:  rd_word = DATA_W'(deb_q[N_IN-1:N_SW]);
            OFF_EDGE: rd_word = DATA_W'(edge_q);
            default:  rd_word = '0;
        endcase
        io_rvalid_d = r_enable && io_sel;
        io_rdata_d  = io_rvalid_d ? rd_word : io_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            cnt_q       <= '0;
            leds_q      <= '0;
            edge_q      <= '0;
            io_rdata_q  <= '0;
            io_rvalid_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            leds_q      <= leds_d;
            edge_q      <= edge_d;
            io_rdata_q  <= io_rdata_d;
            io_rvalid_q <= io_rvalid_d;
        end
    end

    assign io_rdata  = io_rdata_q;
    assign io_rvalid = io_rvalid_q;
    assign leds_out  = leds_q;

endmodule
